// File: rtl/vx_cache_bypass_sched_if.sv
// Memory-request scheduling bus: cache and NC request channels, the shared memory port,
// NC response/drain control. Perf outputs exist only under VX_BYPASS_SCHED_PERF_EN.
interface vx_cache_bypass_sched_if #(
  parameter int DATAW = 64,
  parameter int CNTW  = 3
);
  logic             cache_req_valid;
  logic [DATAW-1:0] cache_req_data;
  logic             cache_req_ready;
  logic             nc_req_valid;
  logic [DATAW-1:0] nc_req_data;
  logic             nc_req_ready;
  logic             mem_req_valid;
  logic [DATAW-1:0] mem_req_data;
  logic             mem_req_is_nc;
  logic             mem_req_ready;
  logic             nc_rsp_fire;
  logic             drain_req;
  logic             drain_busy;
  logic             drain_done;
  logic [CNTW-1:0]  nc_pending;
`ifdef VX_BYPASS_SCHED_PERF_EN
  logic [43:0]      perf_nc_reqs;
  logic [43:0]      perf_forced;
  logic [43:0]      perf_nc_stalls;
`endif

  modport slave (
    input  cache_req_valid, cache_req_data, nc_req_valid, nc_req_data,
    input  mem_req_ready, nc_rsp_fire, drain_req,
    output cache_req_ready, nc_req_ready, mem_req_valid, mem_req_data, mem_req_is_nc,
    output drain_busy, drain_done, nc_pending
`ifdef VX_BYPASS_SCHED_PERF_EN
    , output perf_nc_reqs, perf_forced, perf_nc_stalls
`endif
  );

  modport master (
    output cache_req_valid, cache_req_data, nc_req_valid, nc_req_data,
    output mem_req_ready, nc_rsp_fire, drain_req,
    input  cache_req_ready, nc_req_ready, mem_req_valid, mem_req_data, mem_req_is_nc,
    input  drain_busy, drain_done, nc_pending
`ifdef VX_BYPASS_SCHED_PERF_EN
    , input perf_nc_reqs, perf_forced, perf_nc_stalls
`endif
  );
endinterface

// File: rtl/vx_cache_bypass_sched.sv
// Shares one memory request port between cache and NC bypass traffic with bounded NC starvation,
// an outstanding-NC cap and a drain handshake. Optional perf counters: VX_BYPASS_SCHED_PERF_EN.
module vx_cache_bypass_sched #(
  parameter int DATAW        = 64,
  parameter int MAX_PENDING  = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int CNTW         = $clog2(MAX_PENDING + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  vx_cache_bypass_sched_if.slave  bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNTW-1:0] MAXP = CNTW'(MAX_PENDING);
  localparam logic [SW-1:0]   LIM  = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, DRAIN, DONE, HOLD} state_e;

  state_e          state_q, state_d;
  logic            lock_q, lock_d;
  logic            lock_src_q, lock_src_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [CNTW-1:0] pend_q, pend_d;

  logic nc_elig, force_nc, grant_nc, grant_cache;
  logic mem_valid, nc_fire, any_fire, rsp_dec;
  logic drain_busy, drain_done;

  assign nc_elig  = bus.nc_req_valid && (pend_q < MAXP) && (state_q == IDLE);
  assign force_nc = (starve_q == LIM);

  // Grants are gated by reset so every output reads 0 while reset is held.
  always_comb begin
    grant_nc    = 1'b0;
    grant_cache = 1'b0;
    if (!reset) begin
      if (lock_q) begin
        grant_nc    = lock_src_q;
        grant_cache = !lock_src_q;
      end else if (nc_elig && (force_nc || !bus.cache_req_valid)) begin
        grant_nc    = 1'b1;
      end else begin
        grant_cache = bus.cache_req_valid;
      end
    end
  end

  assign mem_valid = (grant_nc && bus.nc_req_valid) || (grant_cache && bus.cache_req_valid);
  assign nc_fire   = grant_nc && bus.nc_req_valid && bus.mem_req_ready;
  assign any_fire  = mem_valid && bus.mem_req_ready;
  assign rsp_dec   = bus.nc_rsp_fire && (pend_q != '0);

  assign bus.mem_req_valid   = mem_valid;
  assign bus.mem_req_is_nc   = grant_nc && bus.nc_req_valid;
  assign bus.mem_req_data    = grant_nc    ? bus.nc_req_data    :
                               grant_cache ? bus.cache_req_data : '0;
  assign bus.cache_req_ready = bus.mem_req_ready && grant_cache;
  assign bus.nc_req_ready    = bus.mem_req_ready && grant_nc;
  assign bus.nc_pending      = pend_q;
  assign bus.drain_busy      = drain_busy;
  assign bus.drain_done      = drain_done;

  always_comb begin
    lock_d     = lock_q;
    lock_src_d = lock_src_q;
    if (any_fire) begin
      lock_d = 1'b0;
    end else if (mem_valid) begin
      lock_d     = 1'b1;
      lock_src_d = grant_nc;
    end

    starve_d = starve_q;
    if (nc_fire || !bus.nc_req_valid) begin
      starve_d = '0;
    end else if (nc_elig && grant_cache && (starve_q != LIM)) begin
      starve_d = starve_q + SW'(1);
    end

    pend_d = pend_q;
    if (nc_fire && !rsp_dec) begin
      pend_d = pend_q + CNTW'(1);
    end else if (!nc_fire && rsp_dec) begin
      pend_d = pend_q - CNTW'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    drain_busy = 1'b0;
    drain_done = 1'b0;
    case (state_q)
      IDLE: begin
        // A stalled NC request must complete before the drain may start.
        if (bus.drain_req && !(lock_q && lock_src_q)) state_d = DRAIN;
      end
      DRAIN: begin
        drain_busy = 1'b1;
        if (pend_q == '0) state_d = DONE;
      end
      DONE: begin
        drain_done = 1'b1;
        state_d    = bus.drain_req ? HOLD : IDLE;
      end
      HOLD: begin
        drain_busy = 1'b1;
        if (!bus.drain_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      lock_q     <= 1'b0;
      lock_src_q <= 1'b0;
      starve_q   <= '0;
      pend_q     <= '0;
    end else begin
      state_q    <= state_d;
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
      starve_q   <= starve_d;
      pend_q     <= pend_d;
    end
  end

  a_no_rsp_underflow: assert property (@(posedge clk) disable iff (reset)
    !(bus.nc_rsp_fire && pend_q == '0));

`ifdef VX_BYPASS_SCHED_PERF_EN
  logic [43:0] perf_nc_reqs_q, perf_forced_q, perf_nc_stalls_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_nc_reqs_q   <= '0;
      perf_forced_q    <= '0;
      perf_nc_stalls_q <= '0;
    end else begin
      if (nc_fire) perf_nc_reqs_q <= perf_nc_reqs_q + 44'd1;
      // A forced grant is counted once, in the cycle it is first won while unlocked.
      if (!lock_q && grant_nc && force_nc && bus.nc_req_valid)
        perf_forced_q <= perf_forced_q + 44'd1;
      if (bus.nc_req_valid && !bus.nc_req_ready)
        perf_nc_stalls_q <= perf_nc_stalls_q + 44'd1;
    end
  end

  assign bus.perf_nc_reqs   = perf_nc_reqs_q;
  assign bus.perf_forced    = perf_forced_q;
  assign bus.perf_nc_stalls = perf_nc_stalls_q;
`endif
endmodule

// File: tb/tb_vx_cache_bypass_sched.sv
// Directed bench for vx_cache_bypass_sched: starvation forcing, NC cap, lock hold, drain, reset.
module tb_vx_cache_bypass_sched;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  vx_cache_bypass_sched_if #(.DATAW(64), .CNTW(3)) bus ();

  vx_cache_bypass_sched #(
    .DATAW(64), .MAX_PENDING(4), .STARVE_LIMIT(8), .CNTW(3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int fires;
    int pulses;
    reset                = 1'b1;
    bus.cache_req_valid  = 1'b1;
    bus.cache_req_data   = 64'hDEAD;
    bus.nc_req_valid     = 1'b0;
    bus.nc_req_data      = '0;
    bus.mem_req_ready    = 1'b1;
    bus.nc_rsp_fire      = 1'b0;
    bus.drain_req        = 1'b0;
    #2;
    chk("rst_mem_valid", 64'(bus.mem_req_valid), 64'd0);
    chk("rst_cache_ready", 64'(bus.cache_req_ready), 64'd0);
    chk("rst_mem_data", bus.mem_req_data, 64'd0);
    chk("rst_pending", 64'(bus.nc_pending), 64'd0);
    chk("rst_busy", 64'(bus.drain_busy), 64'd0);
    bus.cache_req_valid = 1'b0;
    tick();
    reset = 1'b0;

    // Starvation: cache wins 8 cycles, NC forced on the 9th, cache again after.
    bus.cache_req_valid = 1'b1;
    bus.nc_req_valid    = 1'b1;
    bus.nc_req_data     = 64'hA5A5_0001;
    for (int i = 0; i < 8; i++) begin
      bus.cache_req_data = 64'hC000 + 64'(i);
      #1;
      chk($sformatf("starve_cache_c%0d", i), {62'd0, bus.mem_req_is_nc, bus.cache_req_ready}, 64'd1);
      chk($sformatf("starve_data_c%0d", i), bus.mem_req_data, 64'hC000 + 64'(i));
      tick();
    end
    bus.cache_req_data = 64'hC008;
    #1;
    chk("starve_forced_is_nc", 64'(bus.mem_req_is_nc), 64'd1);
    chk("starve_forced_ready", {62'd0, bus.nc_req_ready, bus.cache_req_ready}, 64'd2);
    chk("starve_forced_data", bus.mem_req_data, 64'hA5A5_0001);
    tick();
    bus.cache_req_data = 64'hC009;
    #1;
    chk("starve_reset_cache", {62'd0, bus.mem_req_is_nc, bus.cache_req_ready}, 64'd1);
    tick();
    chk("starve_pending", 64'(bus.nc_pending), 64'd1);
    bus.cache_req_valid = 1'b0;
    bus.nc_req_valid    = 1'b0;
    bus.nc_rsp_fire     = 1'b1;
    tick();
    bus.nc_rsp_fire = 1'b0;
    chk("starve_cleanup", 64'(bus.nc_pending), 64'd0);

    // NC cap: 6 offered, only 4 accepted, one response frees one slot.
    bus.nc_req_valid = 1'b1;
    fires = 0;
    for (int i = 0; i < 6; i++) begin
      bus.nc_req_data = 64'hB000 + 64'(i);
      #1;
      if (bus.nc_req_ready) fires++;
      tick();
    end
    chk("cap_fires", 64'(fires), 64'd4);
    chk("cap_pending", 64'(bus.nc_pending), 64'd4);
    chk("cap_nc_ready", 64'(bus.nc_req_ready), 64'd0);
    chk("cap_mem_valid", 64'(bus.mem_req_valid), 64'd0);
    bus.nc_rsp_fire = 1'b1;
    tick();
    bus.nc_rsp_fire = 1'b0;
    fires = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (bus.nc_req_ready) fires++;
      tick();
    end
    chk("cap_one_more", 64'(fires), 64'd1);
    chk("cap_pending_full", 64'(bus.nc_pending), 64'd4);
    bus.nc_req_valid = 1'b0;
    bus.nc_rsp_fire  = 1'b1;
    repeat (4) tick();
    bus.nc_rsp_fire = 1'b0;
    chk("cap_cleanup", 64'(bus.nc_pending), 64'd0);

    // Lock: stalled NC request holds the port while cache waits.
    bus.nc_req_valid  = 1'b1;
    bus.nc_req_data   = 64'h1111_2222;
    bus.mem_req_ready = 1'b0;
    #1;
    chk("lock_c0_is_nc", 64'(bus.mem_req_is_nc), 64'd1);
    tick();
    bus.cache_req_valid = 1'b1;
    bus.cache_req_data  = 64'h3333_4444;
    for (int i = 1; i < 3; i++) begin
      #1;
      chk($sformatf("lock_c%0d_data", i), bus.mem_req_data, 64'h1111_2222);
      chk($sformatf("lock_c%0d_flags", i),
          {61'd0, bus.mem_req_is_nc, bus.mem_req_valid, bus.cache_req_ready}, 64'd6);
      tick();
    end
    bus.mem_req_ready = 1'b1;
    #1;
    chk("lock_release_nc_ready", {62'd0, bus.nc_req_ready, bus.mem_req_is_nc}, 64'd3);
    chk("lock_release_data", bus.mem_req_data, 64'h1111_2222);
    tick();
    bus.nc_req_valid = 1'b0;
    #1;
    chk("lock_cache_next", {62'd0, bus.cache_req_ready, bus.mem_req_is_nc}, 64'd2);
    chk("lock_cache_data", bus.mem_req_data, 64'h3333_4444);
    tick();
    bus.cache_req_valid = 1'b0;
    bus.nc_rsp_fire     = 1'b1;
    tick();
    bus.nc_rsp_fire = 1'b0;
    chk("lock_cleanup", 64'(bus.nc_pending), 64'd0);

    // Drain with two outstanding NC requests.
    bus.nc_req_valid = 1'b1;
    repeat (2) tick();
    bus.nc_req_valid = 1'b0;
    chk("drain_pending2", 64'(bus.nc_pending), 64'd2);
    bus.drain_req = 1'b1;
    tick();
    chk("drain_busy", 64'(bus.drain_busy), 64'd1);
    bus.nc_req_valid = 1'b1;
    #1;
    chk("drain_nc_blocked", {62'd0, bus.nc_req_ready, bus.mem_req_valid}, 64'd0);
    bus.cache_req_valid = 1'b1;
    bus.cache_req_data  = 64'h7777;
    #1;
    chk("drain_cache_ok", {62'd0, bus.cache_req_ready, bus.mem_req_is_nc}, 64'd2);
    bus.cache_req_valid = 1'b0;
    bus.nc_rsp_fire     = 1'b1;
    tick();
    tick();
    bus.nc_rsp_fire = 1'b0;
    chk("drain_pending0", 64'(bus.nc_pending), 64'd0);
    chk("drain_done_early", 64'(bus.drain_done), 64'd0);
    tick();
    chk("drain_done_pulse", 64'(bus.drain_done), 64'd1);
    chk("drain_done_nc_blocked", 64'(bus.nc_req_ready), 64'd0);
    tick();
    chk("hold_state", {61'd0, bus.drain_done, bus.drain_busy, bus.nc_req_ready}, 64'd2);
    bus.drain_req = 1'b0;
    tick();
    chk("idle_after_hold", {62'd0, bus.drain_busy, bus.nc_req_ready}, 64'd1);
    tick();
    bus.nc_req_valid = 1'b0;
    chk("idle_nc_accepted", 64'(bus.nc_pending), 64'd1);

    // Simultaneous NC fire and response at pending=3.
    bus.nc_req_valid = 1'b1;
    repeat (2) tick();
    chk("sim_pending3", 64'(bus.nc_pending), 64'd3);
    bus.nc_rsp_fire = 1'b1;
    #1;
    chk("sim_nc_ready", 64'(bus.nc_req_ready), 64'd1);
    tick();
    bus.nc_rsp_fire  = 1'b0;
    bus.nc_req_valid = 1'b0;
    chk("sim_pending_hold", 64'(bus.nc_pending), 64'd3);

    // Asynchronous reset in the middle of a drain.
    bus.nc_rsp_fire = 1'b1;
    tick();
    bus.nc_rsp_fire = 1'b0;
    chk("rstmid_pending2", 64'(bus.nc_pending), 64'd2);
    bus.drain_req = 1'b1;
    tick();
    chk("rstmid_busy", 64'(bus.drain_busy), 64'd1);
    bus.cache_req_valid = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("rstmid_outputs",
        {60'd0, bus.drain_busy, bus.drain_done, bus.mem_req_valid, bus.cache_req_ready}, 64'd0);
    chk("rstmid_pending0", 64'(bus.nc_pending), 64'd0);
    bus.cache_req_valid = 1'b0;
    bus.drain_req       = 1'b0;
    tick();
    reset  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (bus.drain_done) pulses++;
      tick();
    end
    chk("rstmid_no_done", 64'(pulses), 64'd0);
    chk("rstmid_pending_after", 64'(bus.nc_pending), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/vx_cache_bypass_sched.md
Name: vx_cache_bypass_sched

Overview:
- Schedules the single shared memory request port between the cache fill/writeback path and the non-cacheable (NC) bypass path.
- Replaces fixed cache-first priority with bounded-starvation arbitration and caps the number of outstanding NC requests.
- Provides a drain handshake so NC traffic can be quiesced before a flush or reconfiguration.
- Sits between the cache bank memory interface / NC request select and the memory request output.

Parameters:
- DATAW, 64, width of the opaque request payload (rw, addr, byteen, data, tag packed by the caller).
- MAX_PENDING, 4, maximum outstanding NC requests; must be ≥1.
- STARVE_LIMIT, 8, consecutive cycles an NC request may lose to cache traffic before it is forced; must be ≥1.
- CNTW, $clog2(MAX_PENDING+1), width of the pending counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- cache_req_valid  in  1  cache-path request valid.
- cache_req_data  in  DATAW  cache-path payload.
- cache_req_ready  out  1  cache-path request accepted.
- nc_req_valid  in  1  NC-path request valid.
- nc_req_data  in  DATAW  NC-path payload.
- nc_req_ready  out  1  NC-path request accepted.
- mem_req_valid  out  1  memory request valid.
- mem_req_data  out  DATAW  memory request payload.
- mem_req_is_nc  out  1  current memory request came from the NC path.
- mem_req_ready  in  1  memory accepts the request.
- nc_rsp_fire  in  1  one NC response consumed this cycle.
- drain_req  in  1  level; request NC quiesce.
- drain_busy  out  1  drain in progress.
- drain_done  out  1  one-cycle pulse when quiesced.
- nc_pending  out  CNTW  outstanding NC request count.

Behaviour:
- Reset (async assert, sync release): lock=0, lock_src=0, starve_cnt=0, nc_pending=0, FSM=IDLE. All outputs 0.
- nc_eligible = nc_req_valid && nc_pending<MAX_PENDING && FSM==IDLE.
- Grant when unlocked:
  - force = starve_cnt==STARVE_LIMIT.
  - NC is granted if nc_eligible && (force || !cache_req_valid).
  - Otherwise cache is granted if cache_req_valid.
- mem_req_valid = granted source valid. mem_req_data and mem_req_is_nc follow the granted source combinationally (zero latency).
- Lock rule: if mem_req_valid && !mem_req_ready, set lock and record lock_src. While locked, the grant is lock_src regardless of the other source or starve state. The NC eligibility check is bypassed for a locked NC request. Lock clears on fire.
- cache_req_ready = mem_req_ready && grant==cache. nc_req_ready = mem_req_ready && grant==NC.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) each cycle nc_eligible && cache is granted.
  - Resets to 0 on NC fire, or when nc_req_valid=0.
  - Holds otherwise.
- nc_pending: +1 on NC fire, −1 on nc_rsp_fire; both in the same cycle → unchanged. nc_rsp_fire at 0 is an error (assert), and the count holds. The count never exceeds MAX_PENDING.
- FSM IDLE→DRAIN on drain_req, if not locked on NC. If locked on NC, the transition waits for that fire.
- In DRAIN: new NC grants are blocked, cache traffic is unaffected, drain_busy=1.
- DRAIN→DONE when nc_pending==0. This can occur in the first DRAIN cycle.
- DONE: drain_done=1 for exactly one cycle, then go to IDLE if drain_req=0; otherwise go to HOLD.
- HOLD: drain_busy=1, NC stays blocked, returns to IDLE when drain_req=0.
- Reset mid-drain returns to IDLE with no drain_done pulse.

Optional Feature:
- Macro: VX_BYPASS_SCHED_PERF_EN.
- When defined, adds outputs perf_nc_reqs[43:0] (NC fires), perf_forced[43:0] (NC grants taken with force=1) and perf_nc_stalls[43:0] (cycles with nc_req_valid && !nc_req_ready).
- All three counters are async-reset to 0 and wrap on overflow.
- When undefined, these ports and counters are absent and the other behaviour is identical.

Test Plan:
- Cache valid continuously, NC valid from cycle 0, mem_req_ready=1, STARVE_LIMIT=8 → cache fires on cycles 0-7; NC fires on cycle 8 with mem_req_is_nc=1; starve_cnt=0 on cycle 9.
- NC-only stream of 6 requests, MAX_PENDING=4, no responses → 4 fires, nc_pending=4, nc_req_ready=0. One nc_rsp_fire → exactly one more fire.
- NC granted with mem_req_ready=0 for 3 cycles while cache asserts valid → mem_req_data stays at the NC payload and is_nc=1 throughout; NC fires when ready rises; cache is served next.
- nc_pending=2, drain_req held high → drain_busy=1 and NC blocked. Two nc_rsp_fire → drain_done pulses one cycle, FSM goes to HOLD. drain_req drops → IDLE and NC accepted again.
- NC fire and nc_rsp_fire in the same cycle at nc_pending=3 → nc_pending stays 3.
- Reset asserted mid-drain with nc_pending=2 → all outputs 0 immediately (asynchronous), nc_pending=0, no drain_done after release.
